mshr: RTL

Miss status holding register (MSHR) for the global-memory pipeline. It is the receiving end of the miss path out of memory stage 2: it captures each cache miss (block address, emulated latency, warp/scoreboard/register tags, thread mask) and counts its latency down. On expiry it presents a replay request to the warp side. On replay acceptance it returns a one-cycle negative-feedback pulse carrying the block address, so the cache latency emulator can clear its pending-miss state.

---
 rtl/mshr.sv | 111 +++++++++++
 1 files changed

// File: rtl/mshr.sv
// mshr: miss holding registers that count emulated latency down, replay expired misses and pulse feedback on retire
module mshr #(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W = 27,
  parameter int CNT_W = $clog2(NUM_ENTRIES + 1)
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [4:0]        miss_latency,
  input  logic [2:0]        miss_warp_ID,
  input  logic [1:0]        miss_scb_ID,
  input  logic [4:0]        miss_reg_addr,
  input  logic [7:0]        miss_thread_mask,
  input  logic              miss_is_write,
  input  logic              replay_ready,
  output logic              mshr_full,
  output logic              replay_valid,
  output logic [2:0]        replay_warp_ID,
  output logic [1:0]        replay_scb_ID,
  output logic [4:0]        replay_reg_addr,
  output logic [7:0]        replay_thread_mask,
  output logic              replay_is_write,
  output logic [ADDR_W-1:0] replay_addr,
  output logic              mshr_neg_feedback_valid,
  output logic [ADDR_W-1:0] mshr_neg_feedback_addr,
  output logic [CNT_W-1:0]  pending_count,
  output logic              mshr_overflow
);
  localparam int IW = $clog2(NUM_ENTRIES);
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [4:0]        cnt_q  [NUM_ENTRIES];
  logic [4:0]        cnt_d  [NUM_ENTRIES];
  logic [ADDR_W-1:0] addr_q [NUM_ENTRIES];
  logic [2:0]        warp_q [NUM_ENTRIES];
  logic [1:0]        scb_q  [NUM_ENTRIES];
  logic [4:0]        reg_q  [NUM_ENTRIES];
  logic [7:0]        mask_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] wr_q;
  logic [IW-1:0]     free_idx, sel_idx;
  logic              sel_hit, alloc, retire;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic              fb_valid_q, ovf_q;
  logic [ADDR_W-1:0] fb_addr_q;
  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
      if (valid_q[i] && cnt_q[i] == 5'd0) begin
        sel_idx = IW'(i);
        sel_hit = 1'b1;
      end
    end
  end
  assign mshr_full = &valid_q;
  assign alloc = miss_valid && !mshr_full;
  assign retire = sel_hit && replay_ready;
  assign replay_valid = sel_hit;
  assign replay_addr = sel_hit ? addr_q[sel_idx] : '0;
  assign replay_warp_ID = sel_hit ? warp_q[sel_idx] : '0;
  assign replay_scb_ID = sel_hit ? scb_q[sel_idx] : '0;
  assign replay_reg_addr = sel_hit ? reg_q[sel_idx] : '0;
  assign replay_thread_mask = sel_hit ? mask_q[sel_idx] : '0;
  assign replay_is_write = sel_hit && wr_q[sel_idx];
  // Allocation targets an invalid slot and retire a valid one, so they never collide.
  always_comb begin
    valid_d = valid_q;
    if (retire) valid_d[sel_idx] = 1'b0;
    if (alloc) valid_d[free_idx] = 1'b1;
    pending_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cnt_d[i] = (alloc && free_idx == IW'(i)) ? miss_latency :
                 (valid_q[i] && cnt_q[i] != 5'd0) ? cnt_q[i] - 5'd1 : cnt_q[i];
      pending_d = pending_d + CNT_W'(valid_d[i]);
    end
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      valid_q <= '0;
      cnt_q <= '{default: '0};
      pending_q <= '0;
      fb_valid_q <= 1'b0;
      fb_addr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      fb_valid_q <= retire;
      if (retire) fb_addr_q <= replay_addr;
      ovf_q <= ovf_q | (miss_valid && mshr_full);
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[free_idx] <= miss_addr;
      warp_q[free_idx] <= miss_warp_ID;
      scb_q[free_idx] <= miss_scb_ID;
      reg_q[free_idx] <= miss_reg_addr;
      mask_q[free_idx] <= miss_thread_mask;
      wr_q[free_idx] <= miss_is_write;
    end
  end
  assign pending_count = pending_q;
  assign mshr_neg_feedback_valid = fb_valid_q;
  assign mshr_neg_feedback_addr = fb_addr_q;
  assign mshr_overflow = ovf_q;
endmodule
